// File: rtl/decryption_dispatch.sv
// Word-to-byte dispatcher: buffers {word, channel} pairs in a small FIFO and
// serializes each word MSB-first onto a shared byte bus with a one-hot channel strobe.
module decryption_dispatch #(
   parameter int MST_DWIDTH = 32,
   parameter int SYS_DWIDTH = 8,
   parameter int NUM_CH     = 4,
   parameter int SEL_WIDTH  = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_sys,
   input  logic                  rst_n,
   input  logic [SEL_WIDTH-1:0]  select,
   input  logic [MST_DWIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  busy,
   input  logic [NUM_CH-1:0]     ch_busy_i,
   output logic [SYS_DWIDTH-1:0] data_o,
   output logic [NUM_CH-1:0]     valid_o,
   output logic                  overflow_o,
   output logic                  sel_err_o
);

   localparam int RATIO = MST_DWIDTH / SYS_DWIDTH;
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

   localparam logic [CW-1:0]        LAST_BYTE = CW'(RATIO - 1);
   localparam logic [AW:0]          FULL      = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]          CNT_ONE   = 1;
   localparam logic [AW-1:0]        PTR_ONE   = 1;
   localparam logic [CW-1:0]        BYTE_ONE  = 1;
   localparam logic [SEL_WIDTH:0]   CH_LIMIT  = (SEL_WIDTH + 1)'(NUM_CH);
   localparam logic [NUM_CH-1:0]    CH_ONE    = 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t state, state_nxt;

   logic [MST_DWIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [SEL_WIDTH-1:0]  mem_ch   [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count;
   logic                  fifo_empty, sel_ok, push, pop, emit;

   logic [MST_DWIDTH-1:0] shreg;
   logic [SEL_WIDTH-1:0]  ch;
   logic [CW-1:0]         byte_cnt;

   assign busy       = (count == FULL);
   assign fifo_empty = (count == '0);
   assign sel_ok     = ({1'b0, select} < CH_LIMIT);
   assign push       = valid_i && !busy && sel_ok;

   // Buffer storage carries no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk_sys) begin
      if (push) begin
         mem_data[wr_ptr] <= data_i;
         mem_ch[wr_ptr]   <= select;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      count <= count + CNT_ONE;
         else if (!push && pop) count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Popping on the last-byte edge keeps back-to-back words bubble-free.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      emit      = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (!ch_busy_i[ch]) begin
               emit = 1'b1;
               if (byte_cnt == LAST_BYTE) begin
                  if (!fifo_empty) pop       = 1'b1;
                  else             state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         shreg      <= '0;
         ch         <= '0;
         byte_cnt   <= '0;
         data_o     <= '0;
         valid_o    <= '0;
         overflow_o <= 1'b0;
         sel_err_o  <= 1'b0;
      end else begin
         overflow_o <= valid_i && busy;
         sel_err_o  <= valid_i && !busy && !sel_ok;
         valid_o    <= '0;
         if (emit) begin
            data_o   <= shreg[MST_DWIDTH-1 -: SYS_DWIDTH];
            valid_o  <= CH_ONE << ch;
            shreg    <= shreg << SYS_DWIDTH;
            byte_cnt <= byte_cnt + BYTE_ONE;
         end
         if (pop) begin
            shreg    <= mem_data[rd_ptr];
            ch       <= mem_ch[rd_ptr];
            byte_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_decryption_dispatch.sv
// Scoreboard bench for decryption_dispatch: expected bytes queued at stimulus time,
// observed bytes collected by a monitor and compared inside each scenario task.
module tb_decryption_dispatch;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  select = '0;
   logic [31:0] data_i = '0;
   logic        valid_i = 1'b0;
   logic [3:0]  ch_busy = '0;
   logic        busy;
   logic [7:0]  data_o;
   logic [3:0]  valid_o;
   logic        overflow_o, sel_err_o;

   logic [1:0]  select3 = '0;
   logic [31:0] data3 = '0;
   logic        valid3 = 1'b0;
   logic [2:0]  ch_busy3 = '0;
   logic        busy3;
   logic [7:0]  data_o3;
   logic [2:0]  valid_o3;
   logic        ovf3, serr3;

   decryption_dispatch #(
      .MST_DWIDTH(32), .SYS_DWIDTH(8), .NUM_CH(4), .SEL_WIDTH(2), .FIFO_DEPTH(4)
   ) dut (
      .clk_sys(clk), .rst_n(rst_n), .select(select), .data_i(data_i), .valid_i(valid_i),
      .busy(busy), .ch_busy_i(ch_busy), .data_o(data_o), .valid_o(valid_o),
      .overflow_o(overflow_o), .sel_err_o(sel_err_o)
   );

   decryption_dispatch #(
      .MST_DWIDTH(32), .SYS_DWIDTH(8), .NUM_CH(3), .SEL_WIDTH(2), .FIFO_DEPTH(4)
   ) dut3 (
      .clk_sys(clk), .rst_n(rst_n), .select(select3), .data_i(data3), .valid_i(valid3),
      .busy(busy3), .ch_busy_i(ch_busy3), .data_o(data_o3), .valid_o(valid_o3),
      .overflow_o(ovf3), .sel_err_o(serr3)
   );

   typedef struct {int cyc; logic [3:0] v; logic [7:0] d;} obs_t;
   typedef struct {logic [3:0] v; logic [7:0] d;} exp_t;

   obs_t obs[$];
   exp_t exp_q[$];
   obs_t o;
   exp_t x;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && valid_o !== 4'b0000) obs.push_back('{cyc, valid_o, data_o});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [1:0] s, input logic [31:0] d, input bit keep);
      select  = s;
      data_i  = d;
      valid_i = 1'b1;
      if (keep)
         for (int i = 0; i < 4; i++) exp_q.push_back('{4'(4'b0001 << s), d[31-8*i -: 8]});
      tick();
      valid_i = 1'b0;
   endtask

   task automatic wait_obs(input int n);
      for (int k = 0; k < 80 && obs.size() < n; k++) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL reset_valid got=%b want=0000", valid_o); end
      checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", data_o); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if ({overflow_o, sel_err_o} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b want=00", {overflow_o, sel_err_o}); end
      checks++; if (valid_o3 !== 3'b000) begin errors++; $display("FAIL reset_valid3 got=%b want=000", valid_o3); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int e0;
      obs.delete(); exp_q.delete();
      push_word(2'd1, 32'hA1B2C3D4, 1'b1);
      e0 = cyc;
      wait_obs(4);
      checks++; if (obs.size() < 4) begin errors++; $display("FAIL single_timeout got=%0d bytes want=4", obs.size()); end
      for (int i = 0; i < 4 && obs.size() > 0; i++) begin
         o = obs.pop_front(); x = exp_q.pop_front();
         checks++; if ({o.v, o.d} !== {x.v, x.d}) begin errors++; $display("FAIL single_byte%0d got=%b/%h want=%b/%h", i, o.v, o.d, x.v, x.d); end
         checks++; if (o.cyc !== e0 + 2 + i) begin errors++; $display("FAIL single_cycle%0d got=%0d want=%0d", i, o.cyc, e0 + 2 + i); end
      end
      repeat (3) tick();
      checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL single_idle_valid got=%b want=0000", valid_o); end
   endtask

   task automatic test_back_to_back();
      int e0;
      obs.delete(); exp_q.delete();
      push_word(2'd0, 32'h11223344, 1'b1);
      e0 = cyc;
      push_word(2'd2, 32'h55667788, 1'b1);
      wait_obs(8);
      checks++; if (obs.size() < 8) begin errors++; $display("FAIL b2b_timeout got=%0d bytes want=8", obs.size()); end
      for (int i = 0; i < 8 && obs.size() > 0; i++) begin
         o = obs.pop_front(); x = exp_q.pop_front();
         checks++; if ({o.v, o.d} !== {x.v, x.d}) begin errors++; $display("FAIL b2b_byte%0d got=%b/%h want=%b/%h", i, o.v, o.d, x.v, x.d); end
         checks++; if (o.cyc !== e0 + 2 + i) begin errors++; $display("FAIL b2b_cycle%0d got=%0d want=%0d", i, o.cyc, e0 + 2 + i); end
      end
      repeat (3) tick();
   endtask

   task automatic test_stall();
      int e0;
      obs.delete(); exp_q.delete();
      push_word(2'd0, 32'hDEADBEEF, 1'b1);
      e0 = cyc;
      repeat (3) tick();
      ch_busy = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); @(negedge clk);
         checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL stall_valid%0d got=%b want=0000", k, valid_o); end
         checks++; if (data_o !== 8'hAD) begin errors++; $display("FAIL stall_hold%0d got=%h want=ad", k, data_o); end
      end
      ch_busy = 4'b0000;
      wait_obs(4);
      checks++; if (obs.size() < 4) begin errors++; $display("FAIL stall_timeout got=%0d bytes want=4", obs.size()); end
      for (int i = 0; i < 4 && obs.size() > 0; i++) begin
         o = obs.pop_front(); x = exp_q.pop_front();
         checks++; if ({o.v, o.d} !== {x.v, x.d}) begin errors++; $display("FAIL stall_byte%0d got=%b/%h want=%b/%h", i, o.v, o.d, x.v, x.d); end
         checks++; if (o.cyc !== ((i < 2) ? e0 + 2 + i : e0 + 5 + i)) begin errors++; $display("FAIL stall_cycle%0d got=%0d want=%0d", i, o.cyc, (i < 2) ? e0 + 2 + i : e0 + 5 + i); end
      end
      repeat (3) tick();
   endtask

   task automatic test_overflow();
      obs.delete(); exp_q.delete();
      ch_busy = 4'hF;
      // First word parks in the serializer, so the following four fill the buffer.
      push_word(2'd3, 32'h0F1E2D3C, 1'b1);
      push_word(2'd0, 32'h01020304, 1'b1);
      push_word(2'd1, 32'h10203040, 1'b1);
      push_word(2'd2, 32'hCAFEF00D, 1'b1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_early got=%b want=0", busy); end
      push_word(2'd3, 32'h89ABCDEF, 1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy_full got=%b want=1", busy); end
      push_word(2'd1, 32'h5A5A5A5A, 1'b0);
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b want=1", overflow_o); end
      checks++; if (sel_err_o !== 1'b0) begin errors++; $display("FAIL ovf_selerr got=%b want=0", sel_err_o); end
      tick();
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end got=%b want=0", overflow_o); end
      checks++; if (obs.size() != 0) begin errors++; $display("FAIL ovf_quiet got=%0d bytes want=0", obs.size()); end
      ch_busy = 4'h0;
      wait_obs(20);
      checks++; if (obs.size() != 20) begin errors++; $display("FAIL ovf_count got=%0d bytes want=20", obs.size()); end
      for (int i = 0; i < 20 && obs.size() > 0; i++) begin
         o = obs.pop_front(); x = exp_q.pop_front();
         checks++; if ({o.v, o.d} !== {x.v, x.d}) begin errors++; $display("FAIL ovf_byte%0d got=%b/%h want=%b/%h", i, o.v, o.d, x.v, x.d); end
      end
      repeat (3) tick();
   endtask

   task automatic test_bad_select();
      select3 = 2'd3; data3 = 32'h77777777; valid3 = 1'b1;
      tick();
      valid3 = 1'b0;
      checks++; if (serr3 !== 1'b1) begin errors++; $display("FAIL badsel_pulse got=%b want=1", serr3); end
      checks++; if (ovf3 !== 1'b0) begin errors++; $display("FAIL badsel_ovf got=%b want=0", ovf3); end
      tick();
      checks++; if (serr3 !== 1'b0) begin errors++; $display("FAIL badsel_pulse_end got=%b want=0", serr3); end
      for (int k = 0; k < 5; k++) begin
         checks++; if (valid_o3 !== 3'b000) begin errors++; $display("FAIL badsel_valid%0d got=%b want=000", k, valid_o3); end
         tick();
      end
      checks++; if (dut3.count !== 3'd0) begin errors++; $display("FAIL badsel_count got=%0d want=0", dut3.count); end
      select3 = 2'd2; data3 = 32'h0BADF00D; valid3 = 1'b1;
      tick();
      valid3 = 1'b0;
      tick(); tick();
      checks++; if ({valid_o3, data_o3} !== {3'b100, 8'h0B}) begin errors++; $display("FAIL badsel_goodword got=%b/%h want=100/0b", valid_o3, data_o3); end
      checks++; if (serr3 !== 1'b0) begin errors++; $display("FAIL badsel_goodword_err got=%b want=0", serr3); end
      repeat (6) tick();
   endtask

   task automatic test_reset_mid();
      obs.delete(); exp_q.delete();
      push_word(2'd1, 32'hC0C1C2C3, 1'b0);
      push_word(2'd1, 32'hD0D1D2D3, 1'b0);
      push_word(2'd1, 32'hE0E1E2E3, 1'b0);
      tick();
      checks++; if ({valid_o, data_o} !== {4'b0010, 8'hC1}) begin errors++; $display("FAIL rstmid_byte2 got=%b/%h want=0010/c1", valid_o, data_o); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({valid_o, data_o} !== 12'h000) begin errors++; $display("FAIL rstmid_out got=%b/%h want=0000/00", valid_o, data_o); end
      checks++; if ({busy, overflow_o, sel_err_o} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got=%b want=000", {busy, overflow_o, sel_err_o}); end
      obs.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) tick();
      checks++; if (obs.size() != 0) begin errors++; $display("FAIL rstmid_leak got=%0d bytes want=0", obs.size()); end
      checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL rstmid_idle got=%b want=0000", valid_o); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog sim time exceeded");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_overflow();
      test_bad_select();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
